// File: rtl/fmc_lcd_bridge.sv
// fmc_lcd_bridge: re-times asynchronous FMC writes into the core clock domain,
// buffers them in a FIFO and replays them onto an 8080-style LCD bus with
// programmable WR low/high widths.
module fmc_lcd_bridge #(
   parameter int DW    = 24,
   parameter int DEPTH = 16,
   parameter int WR_LO = 2,
   parameter int WR_HI = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_cs,
   input  logic                   i_wr,
   input  logic                   i_rs,
   input  logic [DW-1:0]          i_data,
   input  logic                   i_ovf_clr,
   output logic                   o_cs,
   output logic                   o_rs,
   output logic                   o_wr,
   output logic [DW-1:0]          o_data,
   output logic                   o_busy,
   output logic                   o_ovf,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam int AW   = $clog2(DEPTH);
   localparam int LW   = AW + 1;
   localparam int CMAX = (WR_LO > WR_HI) ? WR_LO : WR_HI;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [1:0] {IDLE, SETUP, WR_LOW, WR_HIGH} state_t;

   // ---------------- input synchroniser ----------------
   logic          s1_wr, s2_wr, s3_wr, s1_cs, s2_cs, s1_rs, s2_rs;
   logic [DW-1:0] s1_data, s2_data;
   logic          wr_event;

   // Two-flop chain on every FMC input; strobes reset high so a released
   // reset with i_wr held high never looks like a rising edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_wr   <= 1'b1;
         s2_wr   <= 1'b1;
         s3_wr   <= 1'b1;
         s1_cs   <= 1'b1;
         s2_cs   <= 1'b1;
         s1_rs   <= 1'b0;
         s2_rs   <= 1'b0;
         s1_data <= '0;
         s2_data <= '0;
      end else begin
         s1_wr   <= i_wr;
         s2_wr   <= s1_wr;
         s3_wr   <= s2_wr;
         s1_cs   <= i_cs;
         s2_cs   <= s1_cs;
         s1_rs   <= i_rs;
         s2_rs   <= s1_rs;
         s1_data <= i_data;
         s2_data <= s1_data;
      end
   end

   // Rising edge of nWE while chip select is low marks one LCD write; the
   // data stage is aligned so s2 holds the word sampled with the first high.
   assign wr_event = s2_wr & ~s3_wr & ~s2_cs;

   // ---------------- FIFO ----------------
   logic [DW:0]   mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [LW-1:0] level;
   logic          pop, push_ok;
   logic [DW:0]   head;

   // A full FIFO still accepts a word when the reader frees a slot this cycle.
   assign push_ok = wr_event & ((level != LW'(DEPTH)) | pop);
   assign head    = mem[rptr];

   // Storage array; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= {s2_rs, s2_data};
   end

   // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (push_ok) wptr <= wptr + AW'(1);
         if (pop)     rptr <= rptr + AW'(1);
         level <= level + LW'(push_ok) - LW'(pop);
      end
   end

   // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst)                      o_ovf <= 1'b0;
      else if (wr_event & ~push_ok) o_ovf <= 1'b1;
      else if (i_ovf_clr)           o_ovf <= 1'b0;
   end

   // ---------------- LCD bus FSM ----------------
   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          cs_d, wr_d, rs_d;
   logic [DW-1:0] data_d;

   // State, phase counter and the registered bus outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         o_cs   <= 1'b1;
         o_wr   <= 1'b1;
         o_rs   <= 1'b0;
         o_data <= '0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         o_cs   <= cs_d;
         o_wr   <= wr_d;
         o_rs   <= rs_d;
         o_data <= data_d;
      end
   end

   // Next-state and next-output logic; words are loaded only on a pop so the
   // bus data stays frozen from SETUP to the end of WR_HIGH.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      cs_d    = o_cs;
      wr_d    = o_wr;
      rs_d    = o_rs;
      data_d  = o_data;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            cs_d = 1'b1;
            wr_d = 1'b1;
            if (level != '0) begin
               pop     = 1'b1;
               rs_d    = head[DW];
               data_d  = head[DW-1:0];
               cs_d    = 1'b0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            wr_d    = 1'b0;
            cnt_d   = '0;
            state_d = WR_LOW;
         end
         WR_LOW: begin
            if (cnt == CW'(WR_LO - 1)) begin
               wr_d    = 1'b1;
               cnt_d   = '0;
               state_d = WR_HIGH;
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         WR_HIGH: begin
            if (cnt == CW'(WR_HI - 1)) begin
               cnt_d = '0;
               if (level != '0) begin
                  pop     = 1'b1;
                  rs_d    = head[DW];
                  data_d  = head[DW-1:0];
                  state_d = SETUP;
               end else begin
                  cs_d    = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         default: begin
            cs_d    = 1'b1;
            wr_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   assign o_busy  = (state != IDLE) | (level != '0);
   assign o_level = level;

endmodule

// File: tb/tb_fmc_lcd_bridge.sv
// tb_fmc_lcd_bridge: randomized FMC write stimulus against a queue-based
// reference of the words the LCD bus must show, on a default-timing instance
// (a) and a slow-timing instance (b) that can be driven into overflow.
module tb_fmc_lcd_bridge;

   logic        clk = 1'b0;
   logic        rst, i_cs, i_wr, i_rs, i_ovf_clr;
   logic [23:0] i_data;

   logic        a_cs, a_rs, a_wr, a_busy, a_ovf;
   logic [23:0] a_data;
   logic [4:0]  a_level;
   logic        b_cs, b_rs, b_wr, b_busy, b_ovf;
   logic [23:0] b_data;
   logic [4:0]  b_level;

   fmc_lcd_bridge #(.DW(24), .DEPTH(16), .WR_LO(2), .WR_HI(2)) dut_a (
      .clk(clk), .rst(rst), .i_cs(i_cs), .i_wr(i_wr), .i_rs(i_rs),
      .i_data(i_data), .i_ovf_clr(i_ovf_clr), .o_cs(a_cs), .o_rs(a_rs),
      .o_wr(a_wr), .o_data(a_data), .o_busy(a_busy), .o_ovf(a_ovf),
      .o_level(a_level));

   fmc_lcd_bridge #(.DW(24), .DEPTH(16), .WR_LO(8), .WR_HI(8)) dut_b (
      .clk(clk), .rst(rst), .i_cs(i_cs), .i_wr(i_wr), .i_rs(i_rs),
      .i_data(i_data), .i_ovf_clr(i_ovf_clr), .o_cs(b_cs), .o_rs(b_rs),
      .o_wr(b_wr), .o_data(b_data), .o_busy(b_busy), .o_ovf(b_ovf),
      .o_level(b_level));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // ---------------- bus monitor ----------------
   logic        mon_rst = 1'b0;
   logic [24:0] got_a[$], got_b[$];
   logic [24:0] a_last = '0;
   logic        pa_wr = 1'b1, pa_cs = 1'b1, pb_wr = 1'b1;
   int          a_falls = 0, a_cs_rises = 0, a_unstable = 0;
   int          a_max = 0, b_max = 0;

   // Captures each word when WR falls and flags any data change before WR rises.
   always @(negedge clk) begin
      if (mon_rst) begin
         got_a.delete();
         got_b.delete();
         a_falls    <= 0;
         a_cs_rises <= 0;
         a_unstable <= 0;
         a_max      <= 0;
         b_max      <= 0;
      end else begin
         if (pa_wr === 1'b1 && a_wr === 1'b0) begin
            got_a.push_back({a_rs, a_data});
            a_last  <= {a_rs, a_data};
            a_falls <= a_falls + 1;
         end
         if (pa_wr === 1'b0 && a_wr === 1'b1 && {a_rs, a_data} !== a_last)
            a_unstable <= a_unstable + 1;
         if (pa_cs === 1'b0 && a_cs === 1'b1) a_cs_rises <= a_cs_rises + 1;
         if (pb_wr === 1'b1 && b_wr === 1'b0) got_b.push_back({b_rs, b_data});
         if (int'(a_level) > a_max) a_max <= int'(a_level);
         if (int'(b_level) > b_max) b_max <= int'(b_level);
      end
      pa_wr <= a_wr;
      pa_cs <= a_cs;
      pb_wr <= b_wr;
   end

   // ---------------- reference model ----------------
   // Words the MCU wrote, in order; with no overflow the bus must replay it exactly.
   logic [24:0] sent_q[$];

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; i_wr = 1'b1; i_cs = 1'b1; i_ovf_clr = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0; mon_rst = 1'b1;
      @(negedge clk);
      #1 mon_rst = 1'b0;
      sent_q.delete();
   endtask

   // One FMC write: nWE low for lo cycles, then high; returns hi-1 cycles after
   // the rising edge so consecutive calls give a period of lo+hi cycles.
   task automatic do_write(input logic cs, input logic rs, input logic [23:0] d,
                           input int lo, input int hi);
      @(negedge clk);
      i_cs = cs; i_rs = rs; i_data = d; i_wr = 1'b0;
      repeat (lo - 1) @(negedge clk);
      @(negedge clk);
      i_wr = 1'b1;
      repeat (hi - 1) @(negedge clk);
   endtask

   task automatic wait_idle(input int bound);
      repeat (4) @(negedge clk);
      for (int c = 0; c < bound && (a_busy !== 1'b0 || b_busy !== 1'b0); c++)
         @(negedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; i_ovf_clr = 1'b0; i_rs = 1'b0; i_data = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         i_wr = c[0]; i_cs = ~c[0];
         @(posedge clk); #1;
         n_cmp++;
         if ({a_cs, a_wr, a_rs, a_data, a_busy, a_ovf, a_level} !== {3'b110, 24'd0, 2'b00, 5'd0}) begin
            n_err++;
            $display("FAIL reset_a: got cs%b wr%b rs%b d%h busy%b ovf%b lvl%0d want 1 1 0 0 0 0 0",
                     a_cs, a_wr, a_rs, a_data, a_busy, a_ovf, a_level);
         end
         n_cmp++;
         if ({b_cs, b_wr, b_rs, b_data, b_busy, b_ovf, b_level} !== {3'b110, 24'd0, 2'b00, 5'd0}) begin
            n_err++;
            $display("FAIL reset_b: got cs%b wr%b rs%b d%h busy%b ovf%b lvl%0d want 1 1 0 0 0 0 0",
                     b_cs, b_wr, b_rs, b_data, b_busy, b_ovf, b_level);
         end
      end
      @(negedge clk);
      i_wr = 1'b1; i_cs = 1'b1; rst = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      n_cmp++;
      if (a_level !== 5'd0 || a_busy !== 1'b0 || got_a.size() != 0) begin
        n_err++;
        $display("FAIL reset_release: got lvl%0d busy%b words%0d want 0 0 0", a_level, a_busy, got_a.size());
      end
   endtask

   task automatic test_single();
      logic cs_e, wr_e;
      do_reset();
      do_write(1'b0, 1'b1, 24'h00ABCD, 2, 1);
      // Returned just before edge N; sample after edges N..N+10.
      for (int k = 0; k <= 10; k++) begin
         @(posedge clk); #1;
         cs_e = !(k >= 3 && k < 3 + 1 + 2 + 2);
         wr_e = !(k >= 4 && k < 4 + 2);
         n_cmp++;
         if (a_cs !== cs_e || a_wr !== wr_e) begin
            n_err++;
            $display("FAIL single_timing N+%0d: got cs%b wr%b want cs%b wr%b", k, a_cs, a_wr, cs_e, wr_e);
         end
         if (k >= 3 && k <= 7) begin
            n_cmp++;
            if ({a_rs, a_data} !== {1'b1, 24'h00ABCD}) begin
               n_err++;
               $display("FAIL single_data N+%0d: got %h want %h", k, {a_rs, a_data}, {1'b1, 24'h00ABCD});
            end
         end
         if (k == 8) begin
            n_cmp++;
            if (a_busy !== 1'b0) begin
               n_err++;
               $display("FAIL single_busy: got %b want 0", a_busy);
            end
         end
      end
   endtask

   task automatic test_burst();
      logic rs;
      do_reset();
      for (int k = 0; k < 18; k++) begin
         rs = 1'($urandom);
         sent_q.push_back({rs, 24'(k)});
         do_write(1'b0, rs, 24'(k), 2, 4);
      end
      wait_idle(1000);
      n_cmp++;
      if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
         n_err++;
         $display("FAIL burst_timeout: got busy %b%b want 00", a_busy, b_busy);
      end
      n_cmp++;
      if (got_a.size() != sent_q.size()) begin
         n_err++;
         $display("FAIL burst_count: got %0d want %0d", got_a.size(), sent_q.size());
      end
      for (int i = 0; i < sent_q.size() && i < got_a.size(); i++) begin
         n_cmp++;
         if (got_a[i] !== sent_q[i]) begin
            n_err++;
            $display("FAIL burst_word[%0d]: got %h want %h", i, got_a[i], sent_q[i]);
         end
      end
      n_cmp++;
      if (a_ovf !== 1'b0 || a_max > 2 || a_unstable != 0) begin
         n_err++;
         $display("FAIL burst_flags: got ovf%b maxlvl%0d unstable%0d want 0 <=2 0", a_ovf, a_max, a_unstable);
      end
   endtask

   task automatic test_random();
      logic        rs;
      logic [23:0] d;
      do_reset();
      for (int k = 0; k < 20; k++) begin
         rs = 1'($urandom);
         d  = 24'($urandom);
         sent_q.push_back({rs, d});
         do_write(1'b0, rs, d, $urandom_range(1, 3), $urandom_range(4, 8));
      end
      wait_idle(1000);
      n_cmp++;
      if (got_a.size() != sent_q.size()) begin
         n_err++;
         $display("FAIL random_count: got %0d want %0d", got_a.size(), sent_q.size());
      end
      for (int i = 0; i < sent_q.size() && i < got_a.size(); i++) begin
         n_cmp++;
         if (got_a[i] !== sent_q[i]) begin
            n_err++;
            $display("FAIL random_word[%0d]: got %h want %h", i, got_a[i], sent_q[i]);
         end
      end
      n_cmp++;
      if (a_ovf !== 1'b0 || a_unstable != 0) begin
         n_err++;
         $display("FAIL random_flags: got ovf%b unstable%0d want 0 0", a_ovf, a_unstable);
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] d;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         d = 24'($urandom);
         sent_q.push_back({1'b0, d});
         do_write(1'b0, 1'b0, d, 1, 1);
      end
      wait_idle(500);
      n_cmp++;
      if (got_a.size() != 4) begin
         n_err++;
         $display("FAIL b2b_count: got %0d want 4", got_a.size());
      end
      for (int i = 0; i < 4 && i < got_a.size(); i++) begin
         n_cmp++;
         if (got_a[i] !== sent_q[i]) begin
            n_err++;
            $display("FAIL b2b_word[%0d]: got %h want %h", i, got_a[i], sent_q[i]);
         end
      end
      // Queued words share one chip-select assertion.
      n_cmp++;
      if (a_cs_rises != 1) begin
         n_err++;
         $display("FAIL b2b_cs_rises: got %0d want 1", a_cs_rises);
      end
   endtask

   task automatic test_overflow();
      logic rs;
      int   j;
      logic found;
      do_reset();
      // Six-cycle spacing outruns instance b's 17-cycle word time, so it must fill.
      for (int k = 0; k < 40; k++) begin
         rs = 1'($urandom);
         sent_q.push_back({rs, 24'(k)});
         do_write(1'b0, rs, 24'(k), 2, 4);
      end
      wait_idle(2000);
      n_cmp++;
      if (b_busy !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_timeout: got busy %b want 0", b_busy);
      end
      n_cmp++;
      if (b_ovf !== 1'b1 || b_max != 16) begin
         n_err++;
         $display("FAIL ovf_flag: got ovf%b maxlvl%0d want 1 16", b_ovf, b_max);
      end
      n_cmp++;
      if (got_b.size() < 16 || got_b.size() >= 40) begin
         n_err++;
         $display("FAIL ovf_count: got %0d want 16..39", got_b.size());
      end
      // Delivered words must be an in-order, duplicate-free subsequence.
      j = 0;
      for (int i = 0; i < got_b.size(); i++) begin
         found = 1'b0;
         while (j < sent_q.size() && !found) begin
            if (sent_q[j] === got_b[i]) found = 1'b1;
            j++;
         end
         n_cmp++;
         if (!found) begin
            n_err++;
            $display("FAIL ovf_subseq[%0d]: got %h want in-order unseen word", i, got_b[i]);
         end
      end
      n_cmp++;
      if (got_a.size() != 40 || a_ovf !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_fast_inst: got %0d words ovf%b want 40 0", got_a.size(), a_ovf);
      end
      @(negedge clk); i_ovf_clr = 1'b1;
      @(negedge clk); i_ovf_clr = 1'b0;
      #1;
      n_cmp++;
      if (b_ovf !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_clear: got %b want 0", b_ovf);
      end
   endtask

   task automatic test_cs_high();
      do_reset();
      for (int k = 0; k < 4; k++) do_write(1'b1, 1'b1, 24'($urandom), 2, 3);
      repeat (10) @(negedge clk);
      #1;
      n_cmp++;
      if (a_max != 0 || b_max != 0 || a_falls != 0 || a_cs !== 1'b1 || a_busy !== 1'b0) begin
         n_err++;
         $display("FAIL cs_high: got maxlvl%0d/%0d falls%0d cs%b busy%b want 0/0 0 1 0",
                  a_max, b_max, a_falls, a_cs, a_busy);
      end
   endtask

   task automatic test_reset_mid();
      logic [23:0] d;
      int          base;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         d = 24'($urandom);
         sent_q.push_back({1'b1, d});
         do_write(1'b0, 1'b1, d, 1, 1);
      end
      for (int c = 0; c < 80 && a_falls < 3; c++) begin
         @(negedge clk); #1;
      end
      n_cmp++;
      if (a_falls != 3 || a_wr !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reach_wrlow: got falls%0d wr%b want 3 0", a_falls, a_wr);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (a_wr !== 1'b1 || a_cs !== 1'b1 || a_level !== 5'd0 || a_busy !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset: got wr%b cs%b lvl%0d busy%b want 1 1 0 0", a_wr, a_cs, a_level, a_busy);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      #1;
      base = got_a.size();
      n_cmp++;
      if (base != 3) begin
         n_err++;
         $display("FAIL mid_no_more: got %0d words want 3", base);
      end
      for (int i = 0; i < 3 && i < base; i++) begin
         n_cmp++;
         if (got_a[i] !== sent_q[i]) begin
            n_err++;
            $display("FAIL mid_word[%0d]: got %h want %h", i, got_a[i], sent_q[i]);
         end
      end
      d = 24'($urandom);
      do_write(1'b0, 1'b0, d, 2, 2);
      wait_idle(500);
      n_cmp++;
      if (got_a.size() != base + 1 || got_a[got_a.size() - 1] !== {1'b0, d}) begin
         n_err++;
         $display("FAIL mid_after: got %0d words last %h want %0d last %h",
                  got_a.size(), got_a[got_a.size() - 1], base + 1, {1'b0, d});
      end
   endtask

   initial begin
      rst = 1'b1; i_cs = 1'b1; i_wr = 1'b1; i_rs = 1'b0; i_data = '0; i_ovf_clr = 1'b0;
      test_reset();
      test_single();
      test_burst();
      test_random();
      test_back_to_back();
      test_overflow();
      test_cs_high();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
